// File: rtl/dram_port_arbiter.sv
// Purpose: shares one single-port synchronous DRAM between four cores; round-robin grant (fixed priority with DRAM_ARB_FIXED_PRIO_EN).
// Latency: ack two cycles after the request is sampled in IDLE for a write, three for a read; one transaction in flight.
// Backpressure: a requester holds i_req_n high until its ack; requests seen outside IDLE simply wait for the next IDLE cycle.
module dram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_1,
  input  logic              i_req_2,
  input  logic              i_req_3,
  input  logic              i_req_4,
  input  logic              i_we_1,
  input  logic              i_we_2,
  input  logic              i_we_3,
  input  logic              i_we_4,
  input  logic [ADDR_W-1:0] i_addr_1,
  input  logic [ADDR_W-1:0] i_addr_2,
  input  logic [ADDR_W-1:0] i_addr_3,
  input  logic [ADDR_W-1:0] i_addr_4,
  input  logic [DATA_W-1:0] i_wdata_1,
  input  logic [DATA_W-1:0] i_wdata_2,
  input  logic [DATA_W-1:0] i_wdata_3,
  input  logic [DATA_W-1:0] i_wdata_4,
  output logic [DATA_W-1:0] o_rdata_1,
  output logic [DATA_W-1:0] o_rdata_2,
  output logic [DATA_W-1:0] o_rdata_3,
  output logic [DATA_W-1:0] o_rdata_4,
  output logic              o_ack_1,
  output logic              o_ack_2,
  output logic              o_ack_3,
  output logic              o_ack_4,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_rden,
  output logic              o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_q,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        req;
  logic [3:0]        we;
  logic [ADDR_W-1:0] addr_a  [4];
  logic [DATA_W-1:0] wdata_a [4];
  logic [DATA_W-1:0] rdata_q [4];
  logic [3:0]        ack_vec;

  logic              gnt_vld;
  logic [1:0]        gnt_idx;
  logic [1:0]        cand;
  logic [1:0]        last_idx;
  logic [1:0]        win_idx;
  logic              lat_we;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  assign req        = {i_req_4, i_req_3, i_req_2, i_req_1};
  assign we         = {i_we_4, i_we_3, i_we_2, i_we_1};
  assign addr_a[0]  = i_addr_1;
  assign addr_a[1]  = i_addr_2;
  assign addr_a[2]  = i_addr_3;
  assign addr_a[3]  = i_addr_4;
  assign wdata_a[0] = i_wdata_1;
  assign wdata_a[1] = i_wdata_2;
  assign wdata_a[2] = i_wdata_3;
  assign wdata_a[3] = i_wdata_4;

  assign o_rdata_1   = rdata_q[0];
  assign o_rdata_2   = rdata_q[1];
  assign o_rdata_3   = rdata_q[2];
  assign o_rdata_4   = rdata_q[3];
  assign o_ack_1     = ack_vec[0];
  assign o_ack_2     = ack_vec[1];
  assign o_ack_3     = ack_vec[2];
  assign o_ack_4     = ack_vec[3];
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

`ifdef DRAM_ARB_FIXED_PRIO_EN
  // Fixed-priority pick: scan from port 4 down so port 1 is written last and wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = 2'(i);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end
`else
  // Round-robin pick: scan offsets 4..1 from the last grant so offset 1 (next port) wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_idx + 2'(k);
      if (req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end
`endif

  // State register; reset wins over everything and aborts an in-flight access.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the strobes, acks and busy flag decoded from the current state.
  always_comb begin
    state_nxt  = state;
    o_mem_rden = 1'b0;
    o_mem_wren = 1'b0;
    ack_vec    = 4'b0000;
    o_busy     = 1'b1;
    case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (gnt_vld) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_mem_rden = ~lat_we;
        o_mem_wren = lat_we;
        state_nxt  = lat_we ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        state_nxt = ST_ACK;
      end
      ST_ACK: begin
        ack_vec[win_idx] = 1'b1;
        state_nxt        = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant latch, DRAM address/data holding registers and per-port read data capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      win_idx     <= 2'd0;
      last_idx    <= 2'd3;
      lat_we      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < 4; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      if (state == ST_IDLE && gnt_vld) begin
        win_idx     <= gnt_idx;
        last_idx    <= gnt_idx;
        lat_we      <= we[gnt_idx];
        mem_addr_q  <= addr_a[gnt_idx];
        mem_wdata_q <= wdata_a[gnt_idx];
      end
      if (state == ST_WAIT) begin
        rdata_q[win_idx] <= i_mem_q;
      end
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Purpose: self-checking bench for dram_port_arbiter with a behavioural synchronous DRAM.
// Latency: inputs driven and outputs sampled on the falling edge; cycle 0 is the sampling IDLE cycle.
// Backpressure: requesters hold req until ack, as a real core would.
module tb_dram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req   [4];
  logic        we    [4];
  logic [15:0] addr  [4];
  logic [7:0]  wdata [4];
  logic [7:0]  rd    [4];
  logic        ack   [4];
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_q;
  logic        mem_rden, mem_wren, busy;
  logic [7:0]  mem [256];
  logic [7:0]  exp_rd [4];

  int checks   = 0;
  int failures = 0;

  dram_port_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_1(req[0]), .i_req_2(req[1]), .i_req_3(req[2]), .i_req_4(req[3]),
    .i_we_1(we[0]), .i_we_2(we[1]), .i_we_3(we[2]), .i_we_4(we[3]),
    .i_addr_1(addr[0]), .i_addr_2(addr[1]), .i_addr_3(addr[2]), .i_addr_4(addr[3]),
    .i_wdata_1(wdata[0]), .i_wdata_2(wdata[1]), .i_wdata_3(wdata[2]), .i_wdata_4(wdata[3]),
    .o_rdata_1(rd[0]), .o_rdata_2(rd[1]), .o_rdata_3(rd[2]), .o_rdata_4(rd[3]),
    .o_ack_1(ack[0]), .o_ack_2(ack[1]), .o_ack_3(ack[2]), .o_ack_4(ack[3]),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_rden(mem_rden), .o_mem_wren(mem_wren),
    .i_mem_q(mem_q), .o_busy(busy)
  );

  // Behavioural single-port synchronous DRAM, indexed by the low address byte.
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_rden) mem_q <= mem[mem_addr[7:0]];
  end

  typedef struct {
    int          port;       // 1..4
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;  // reads only
    int          exp_lat;    // ack cycle after sampling
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int ack_count();
    int n = 0;
    for (int j = 0; j < 4; j++) if (ack[j]) n++;
    return n;
  endfunction

  function automatic int ack_port();
    int p = 0;
    for (int j = 0; j < 4; j++) if (ack[j]) p = j + 1;
    return p;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int j = 0; j < 4; j++) req[j] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) exp_rd[j] = 8'h00;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_rden"},  {31'd0, mem_rden}, 32'd0);
    chk({tag, "_wren"},  {31'd0, mem_wren}, 32'd0);
    chk({tag, "_addr"},  {16'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
    chk({tag, "_acks"},  ack_count(), 32'd0);
    for (int j = 0; j < 4; j++) chk({tag, "_rdata"}, {24'd0, rd[j]}, 32'd0);
  endtask

  task automatic apply_vec(input vec_t v, input int vi);
    int p;
    int lat;
    int nr;
    int nw;
    p   = v.port - 1;
    lat = -1;
    nr  = 0;
    nw  = 0;
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", vi), {31'd0, busy}, 32'd0);
    req[p] = 1'b1; we[p] = v.we; addr[p] = v.addr; wdata[p] = v.wdata;
    for (int c = 1; c <= 6 && lat < 0; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d_c%0d_busy", vi, c), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_c%0d_mem_addr", vi, c), {16'd0, mem_addr}, {16'd0, v.addr});
      chk($sformatf("v%0d_c%0d_mem_wdata", vi, c), {24'd0, mem_wdata}, {24'd0, v.wdata});
      if (mem_rden && mem_wren) chk($sformatf("v%0d_both_strobes", vi), 32'd1, 32'd0);
      if (ack_count() != 0 && ack_port() != v.port)
        chk($sformatf("v%0d_stray_ack", vi), ack_port(), v.port);
      nr += int'(mem_rden);
      nw += int'(mem_wren);
      if (ack[p]) lat = c;
      if (c == 1) begin
        // post-grant changes must not reach the DRAM
        we[p] = ~we[p]; addr[p] = addr[p] ^ 16'hFFFF; wdata[p] = wdata[p] ^ 8'hFF;
      end
    end
    req[p] = 1'b0;
    if (!v.we) exp_rd[p] = v.exp_rdata;
    chk($sformatf("v%0d_ack_latency", vi), lat, v.exp_lat);
    chk($sformatf("v%0d_rden_cycles", vi), nr, v.we ? 0 : 1);
    chk($sformatf("v%0d_wren_cycles", vi), nw, v.we ? 1 : 0);
    for (int j = 0; j < 4; j++)
      chk($sformatf("v%0d_rdata_%0d", vi, j + 1), {24'd0, rd[j]}, {24'd0, exp_rd[j]});
    @(negedge clk);
    chk($sformatf("v%0d_ack_one_cycle", vi), ack_count(), 0);
    chk($sformatf("v%0d_back_idle", vi), {31'd0, busy}, 32'd0);
  endtask

  int exp_order [5];
  int exp_acks  [4];
  int got_acks  [4];

  initial begin
    int a0_cyc, a1_cyc, a0_n, a1_n;
    bit seen;

    rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      req[j] = 1'b0; we[j] = 1'b0; addr[j] = 16'h0; wdata[j] = 8'h0;
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem[8'h30] = 8'h11;
    mem_q = 8'h00;

    vecs[0] = '{port: 2, we: 1'b0, addr: 16'h0010, wdata: 8'h00, exp_rdata: 8'h5A, exp_lat: 3};
    vecs[1] = '{port: 3, we: 1'b1, addr: 16'h1234, wdata: 8'hC3, exp_rdata: 8'h00, exp_lat: 2};
    vecs[2] = '{port: 1, we: 1'b0, addr: 16'h1234, wdata: 8'h00, exp_rdata: 8'hC3, exp_lat: 3};
    vecs[3] = '{port: 1, we: 1'b0, addr: 16'h0030, wdata: 8'h00, exp_rdata: 8'h11, exp_lat: 3};
    vecs[4] = '{port: 4, we: 1'b1, addr: 16'h0040, wdata: 8'h77, exp_rdata: 8'h00, exp_lat: 2};
    vecs[5] = '{port: 4, we: 1'b0, addr: 16'h0040, wdata: 8'h00, exp_rdata: 8'h77, exp_lat: 3};

    do_reset();
    check_reset_vals("reset");

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

    // Contention: all four read and keep requesting.
`ifdef DRAM_ARB_FIXED_PRIO_EN
    exp_order = '{1, 1, 1, 1, 1};
    exp_acks  = '{5, 0, 0, 0};
`else
    exp_order = '{1, 2, 3, 4, 1};
    exp_acks  = '{2, 1, 1, 1};
`endif
    do_reset();
    for (int j = 0; j < 4; j++) got_acks[j] = 0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      req[j] = 1'b1; we[j] = 1'b0; addr[j] = 16'h0010; wdata[j] = 8'h00;
    end
    for (int g = 0; g < 5; g++) begin
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(negedge clk);
        if (ack_count() != 0) begin
          seen = 1'b1;
          chk($sformatf("cont_g%0d_onehot", g), ack_count(), 1);
          chk($sformatf("cont_g%0d_port", g), ack_port(), exp_order[g]);
          for (int j = 0; j < 4; j++) if (ack[j]) got_acks[j]++;
        end
      end
      if (!seen) chk($sformatf("cont_g%0d_timeout", g), 0, 1);
    end
    for (int j = 0; j < 4; j++) req[j] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("cont_no_extra_ack", ack_count(), 0);
    end
    chk("cont_idle_after", {31'd0, busy}, 32'd0);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("cont_acks_%0d", j + 1), got_acks[j], exp_acks[j]);
      if (exp_acks[j] != 0) exp_rd[j] = 8'h5A;
      chk($sformatf("cont_rdata_%0d", j + 1), {24'd0, rd[j]}, {24'd0, exp_rd[j]});
    end

    // Reset during WAIT aborts the read with no ack.
    do_reset();
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0010; wdata[1] = 8'h00;
    @(negedge clk);
    chk("rstmid_issue_rden", {31'd0, mem_rden}, 32'd1);
    @(negedge clk);
    chk("rstmid_wait_busy", {31'd0, busy}, 32'd1);
    chk("rstmid_wait_rden", {31'd0, mem_rden}, 32'd0);
    rst = 1'b1;
    req[1] = 1'b0;
    @(negedge clk);
    check_reset_vals("rstmid");
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rstmid_no_ack", ack_count(), 0);
    end

    // Port 1 drops req in ISSUE; port 2 arrives mid-transaction and must wait.
    do_reset();
    a0_cyc = -1; a1_cyc = -1; a0_n = 0; a1_n = 0;
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0030; wdata[0] = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req[0] = 1'b0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0010; wdata[1] = 8'h00;
      end
      if (ack[0]) begin a0_n++; a0_cyc = c; end
      if (ack[1]) begin a1_n++; a1_cyc = c; req[1] = 1'b0; end
    end
    chk("drop_ack1_cycle", a0_cyc, 3);
    chk("drop_ack1_count", a0_n, 1);
    chk("drop_ack2_cycle", a1_cyc, 7);
    chk("drop_ack2_count", a1_n, 1);
    chk("drop_rdata_1", {24'd0, rd[0]}, 32'h11);
    chk("drop_rdata_2", {24'd0, rd[1]}, 32'h5A);
    chk("drop_idle_end", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
